// File: rtl/irq_controller.sv
// Prioritised interrupt/trap controller: sync + edge-detect sources, latch pending, fixed-priority request to CPU.
// Latency: input edge before clock k -> pending at k+SYNC_STAGES+1, cpu_irq at k+SYNC_STAGES+2.
// Backpressure: request held with frozen vector until cpu_ack; next arbitration waits for cpu_eoi. Option: TRAP_PREEMPT_EN.
module irq_controller #(
    parameter int NUM_IRQ     = 8,
    parameter int VEC_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               trap,
    input  logic               cfg_we,
    input  logic [NUM_IRQ-1:0] cfg_mask,
    output logic [NUM_IRQ-1:0] mask,
    output logic [NUM_IRQ:0]   pending,
    output logic               cpu_irq,
    output logic [VEC_W-1:0]   vector,
    input  logic               cpu_ack,
    input  logic               cpu_eoi,
    output logic               in_service
);

    // Source index 0 is the trap, index i+1 is irq_in[i]; this matches both
    // the pending bit layout and the vector encoding.
    localparam int SRC = NUM_IRQ + 1;

`ifdef TRAP_PREEMPT_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERVICE,
        ST_TREQ,
        ST_TSERVICE
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERVICE
    } state_t;
`endif

    logic [SRC-1:0]     src;
    logic [SRC-1:0]     sync_q [SYNC_STAGES];
    logic [SRC-1:0]     dly_q;
    logic [SRC-1:0]     rise_q;
    logic [SRC-1:0]     pend_q;
    logic [SRC-1:0]     pend_d;
    logic [SRC-1:0]     clr_v;
    logic [SRC-1:0]     elig;
    logic [NUM_IRQ-1:0] mask_q;

    logic               win_vld;
    logic [VEC_W-1:0]   win_idx;

    state_t             state_q;
    state_t             state_d;
    logic               cpu_irq_q;
    logic               cpu_irq_d;
    logic [VEC_W-1:0]   vector_q;
    logic [VEC_W-1:0]   vector_d;
    logic               isv_q;
    logic               isv_d;

`ifdef TRAP_PREEMPT_EN
    // Vector of the maskable handler interrupted by a trap (one-deep nesting).
    logic [VEC_W-1:0]   saved_q;
    logic [VEC_W-1:0]   saved_d;
`endif

    assign src = {irq_in, trap};

    // Synchroniser chain, one extra delay flop, and a registered rising-edge pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            dly_q  <= '0;
            rise_q <= '0;
        end else begin
            sync_q[0] <= src;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            dly_q  <= sync_q[SYNC_STAGES-1];
            rise_q <= sync_q[SYNC_STAGES-1] & ~dly_q;
        end
    end

    // A new edge on a source being cleared in the same cycle keeps its bit set.
    assign pend_d = (pend_q & ~clr_v) | rise_q;

    // Pending latch and mask register; mask powers up with everything masked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '0;
            mask_q <= '1;
        end else begin
            pend_q <= pend_d;
            if (cfg_we) begin
                mask_q <= cfg_mask;
            end
        end
    end

    // Trap is never masked; masking only hides pending irqs from arbitration.
    assign elig = {pend_q[SRC-1:1] & ~mask_q, pend_q[0]};

    // Fixed priority: lowest source index wins (trap first).
    always_comb begin
        win_vld = |elig;
        win_idx = '0;
        for (int i = SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_idx = VEC_W'(i);
            end
        end
    end

    // Handshake FSM state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cpu_irq_q <= 1'b0;
            vector_q  <= '0;
            isv_q     <= 1'b0;
`ifdef TRAP_PREEMPT_EN
            saved_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cpu_irq_q <= cpu_irq_d;
            vector_q  <= vector_d;
            isv_q     <= isv_d;
`ifdef TRAP_PREEMPT_EN
            saved_q   <= saved_d;
`endif
        end
    end

    // Next-state and next-output logic; ack/eoi in the wrong state fall through unchanged.
    always_comb begin
        state_d   = state_q;
        cpu_irq_d = cpu_irq_q;
        vector_d  = vector_q;
        isv_d     = isv_q;
        clr_v     = '0;
`ifdef TRAP_PREEMPT_EN
        saved_d   = saved_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d   = ST_REQ;
                    cpu_irq_d = 1'b1;
                    vector_d  = win_idx;
                end
            end
            ST_REQ: begin
                // Vector stays frozen here: no preemption, and a late mask
                // write on the winner does not withdraw the request.
                if (cpu_ack) begin
                    clr_v     = SRC'(1) << vector_q;
                    cpu_irq_d = 1'b0;
                    isv_d     = 1'b1;
                    state_d   = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (cpu_eoi) begin
                    isv_d   = 1'b0;
                    state_d = ST_IDLE;
                end
`ifdef TRAP_PREEMPT_EN
                else if (pend_q[0] && (vector_q != '0)) begin
                    saved_d   = vector_q;
                    vector_d  = '0;
                    cpu_irq_d = 1'b1;
                    state_d   = ST_TREQ;
                end
`endif
            end
`ifdef TRAP_PREEMPT_EN
            ST_TREQ: begin
                if (cpu_ack) begin
                    clr_v[0]  = 1'b1;
                    cpu_irq_d = 1'b0;
                    state_d   = ST_TSERVICE;
                end
            end
            ST_TSERVICE: begin
                // Return to the interrupted handler; in_service never drops.
                if (cpu_eoi) begin
                    vector_d = saved_q;
                    state_d  = ST_SERVICE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mask       = mask_q;
    assign pending    = pend_q;
    assign cpu_irq    = cpu_irq_q;
    assign vector     = vector_q;
    assign in_service = isv_q;

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] irq_in = '0;
    logic       trap = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_mask = '0;
    logic       cpu_ack = 1'b0;
    logic       cpu_eoi = 1'b0;
    logic [7:0] mask;
    logic [8:0] pending;
    logic       cpu_irq;
    logic [3:0] vector;
    logic       in_service;

    int checks = 0;
    int errors = 0;

    irq_controller #(.NUM_IRQ(8), .VEC_W(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .trap       (trap),
        .cfg_we     (cfg_we),
        .cfg_mask   (cfg_mask),
        .mask       (mask),
        .pending    (pending),
        .cpu_irq    (cpu_irq),
        .vector     (vector),
        .cpu_ack    (cpu_ack),
        .cpu_eoi    (cpu_eoi),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] irq;
        logic       trp;
        logic       we;
        logic [7:0] msk;
        logic       ack;
        logic       eoi;
        logic [8:0] pend;
        logic       cirq;
        logic [3:0] vec;
        logic       isv;
        logic [7:0] mk;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic rst, input logic [7:0] irq, input logic trp,
                               input logic we, input logic [7:0] msk, input logic ack,
                               input logic eoi, input logic [8:0] pend, input logic cirq,
                               input logic [3:0] vec, input logic isv, input logic [7:0] mk);
        vec_t r;
        r.rst = rst; r.irq = irq; r.trp = trp; r.we = we; r.msk = msk; r.ack = ack;
        r.eoi = eoi; r.pend = pend; r.cirq = cirq; r.vec = vec; r.isv = isv; r.mk = mk;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, sample 1 time unit after the rising edge.
    task automatic cyc(input logic [7:0] i, input logic t, input logic we, input logic [7:0] m,
                       input logic a, input logic e);
        @(negedge clk);
        irq_in = i; trap = t; cfg_we = we; cfg_mask = m; cpu_ack = a; cpu_eoi = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst irq  trp we msk   ack eoi | pend  cirq vec isv mask   (expected after that edge)
        tbl.push_back(v(0, 8'h00, 0, 0, 8'h00, 0, 0, 9'h000, 0, 4'd0, 0, 8'hFF)); // 0 reset
        tbl.push_back(v(0, 8'h00, 0, 0, 8'h00, 0, 0, 9'h000, 0, 4'd0, 0, 8'hFF)); // 1
        tbl.push_back(v(1, 8'h08, 0, 0, 8'h00, 0, 0, 9'h000, 0, 4'd0, 0, 8'hFF)); // 2 irq3 while masked
        tbl.push_back(v(1, 8'h08, 0, 0, 8'h00, 0, 0, 9'h000, 0, 4'd0, 0, 8'hFF)); // 3
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h000, 0, 4'd0, 0, 8'hFF)); // 4
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h010, 0, 4'd0, 0, 8'hFF)); // 5 pending, no req
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h010, 0, 4'd0, 0, 8'hFF)); // 6
        tbl.push_back(v(1, 8'h00, 0, 1, 8'h00, 0, 0, 9'h010, 0, 4'd0, 0, 8'h00)); // 7 unmask, not yet seen
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h010, 1, 4'd4, 0, 8'h00)); // 8 masked event fires
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 1, 0, 9'h000, 0, 4'd4, 1, 8'h00)); // 9 ack
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h000, 0, 4'd4, 1, 8'h00)); // 10
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 1, 9'h000, 0, 4'd4, 0, 8'h00)); // 11 eoi
        tbl.push_back(v(1, 8'h08, 0, 0, 8'h00, 0, 0, 9'h000, 0, 4'd4, 0, 8'h00)); // 12 irq3 rises (k)
        tbl.push_back(v(1, 8'h08, 0, 0, 8'h00, 0, 0, 9'h000, 0, 4'd4, 0, 8'h00)); // 13
        tbl.push_back(v(1, 8'h08, 0, 0, 8'h00, 0, 0, 9'h000, 0, 4'd4, 0, 8'h00)); // 14
        tbl.push_back(v(1, 8'h08, 0, 0, 8'h00, 0, 0, 9'h010, 0, 4'd4, 0, 8'h00)); // 15 k+3 pending
        tbl.push_back(v(1, 8'h08, 0, 0, 8'h00, 0, 0, 9'h010, 1, 4'd4, 0, 8'h00)); // 16 k+4 cpu_irq
        tbl.push_back(v(1, 8'h08, 0, 0, 8'h00, 1, 0, 9'h000, 0, 4'd4, 1, 8'h00)); // 17 ack
        tbl.push_back(v(1, 8'h08, 0, 0, 8'h00, 0, 0, 9'h000, 0, 4'd4, 1, 8'h00)); // 18 level: no retrigger
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 1, 9'h000, 0, 4'd4, 0, 8'h00)); // 19 eoi
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h000, 0, 4'd4, 0, 8'h00)); // 20
        tbl.push_back(v(1, 8'h22, 0, 0, 8'h00, 0, 0, 9'h000, 0, 4'd4, 0, 8'h00)); // 21 irq5+irq1
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h000, 0, 4'd4, 0, 8'h00)); // 22
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h000, 0, 4'd4, 0, 8'h00)); // 23
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h044, 0, 4'd4, 0, 8'h00)); // 24
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h044, 1, 4'd2, 0, 8'h00)); // 25 irq1 first
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 1, 0, 9'h040, 0, 4'd2, 1, 8'h00)); // 26
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 1, 9'h040, 0, 4'd2, 0, 8'h00)); // 27
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h040, 1, 4'd6, 0, 8'h00)); // 28 then irq5
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 1, 0, 9'h000, 0, 4'd6, 1, 8'h00)); // 29
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 1, 9'h000, 0, 4'd6, 0, 8'h00)); // 30
        tbl.push_back(v(1, 8'h01, 1, 0, 8'h00, 0, 0, 9'h000, 0, 4'd6, 0, 8'h00)); // 31 trap+irq0
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h000, 0, 4'd6, 0, 8'h00)); // 32
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h000, 0, 4'd6, 0, 8'h00)); // 33
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h003, 0, 4'd6, 0, 8'h00)); // 34
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h003, 1, 4'd0, 0, 8'h00)); // 35 trap first
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 1, 0, 9'h002, 0, 4'd0, 1, 8'h00)); // 36
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 1, 9'h002, 0, 4'd0, 0, 8'h00)); // 37
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h002, 1, 4'd1, 0, 8'h00)); // 38 then irq0
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 1, 0, 9'h000, 0, 4'd1, 1, 8'h00)); // 39
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 1, 9'h000, 0, 4'd1, 0, 8'h00)); // 40
        tbl.push_back(v(1, 8'h00, 1, 1, 8'hFF, 0, 0, 9'h000, 0, 4'd1, 0, 8'hFF)); // 41 mask all, trap
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h000, 0, 4'd1, 0, 8'hFF)); // 42
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h000, 0, 4'd1, 0, 8'hFF)); // 43
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h001, 0, 4'd1, 0, 8'hFF)); // 44
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 0, 9'h001, 1, 4'd0, 0, 8'hFF)); // 45 trap unmaskable
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 1, 0, 9'h000, 0, 4'd0, 1, 8'hFF)); // 46
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 1, 9'h000, 0, 4'd0, 0, 8'hFF)); // 47
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 0, 1, 9'h000, 0, 4'd0, 0, 8'hFF)); // 48 stray eoi
        tbl.push_back(v(1, 8'h00, 0, 0, 8'h00, 1, 0, 9'h000, 0, 4'd0, 0, 8'hFF)); // 49 stray ack

        foreach (tbl[r]) begin
            @(negedge clk);
            reset = tbl[r].rst; irq_in = tbl[r].irq; trap = tbl[r].trp; cfg_we = tbl[r].we;
            cfg_mask = tbl[r].msk; cpu_ack = tbl[r].ack; cpu_eoi = tbl[r].eoi;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d{pend,irq,vec,isv,mask}", r),
                32'({pending, cpu_irq, vector, in_service, mask}),
                32'({tbl[r].pend, tbl[r].cirq, tbl[r].vec, tbl[r].isv, tbl[r].mk}));
        end

        // Set-wins on ack-clear, and masking the winner while in REQ.
        cyc(8'h00, 0, 1, 8'h00, 0, 0);
        chk("unmask", 32'(mask), 32'h00);
        cyc(8'h08, 0, 0, 8'h00, 0, 0);
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        cyc(8'h08, 0, 0, 8'h00, 0, 0);
        chk("sw_pend", 32'(pending), 32'h010);
        cyc(8'h08, 0, 0, 8'h00, 0, 0);
        chk("sw_req", 32'({cpu_irq, vector}), 32'h14);
        cyc(8'h08, 0, 1, 8'h08, 0, 0);
        chk("req_masked_holds", 32'({cpu_irq, vector, mask}), 32'h1408);
        cyc(8'h08, 0, 0, 8'h00, 1, 0);
        chk("set_wins_ack", 32'({pending, cpu_irq, in_service}), 32'({9'h010, 1'b0, 1'b1}));
        cyc(8'h00, 0, 0, 8'h00, 0, 1);
        chk("sw_eoi", 32'(in_service), 32'h0);
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        chk("masked_waits", 32'({pending, cpu_irq}), 32'({9'h010, 1'b0}));
        cyc(8'h00, 0, 1, 8'h00, 0, 0);
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        chk("unmask_fires", 32'({cpu_irq, vector}), 32'h14);
        cyc(8'h00, 0, 0, 8'h00, 1, 0);
        cyc(8'h00, 0, 0, 8'h00, 0, 1);

        // Trap arriving while servicing vector 3 (irq_in[2]).
        cyc(8'h04, 0, 0, 8'h00, 0, 0);
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        chk("v3_pend", 32'(pending), 32'h008);
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        chk("v3_req", 32'({cpu_irq, vector}), 32'h13);
        cyc(8'h00, 0, 0, 8'h00, 1, 0);
        chk("v3_ack", 32'({pending, cpu_irq, in_service}), 32'({9'h000, 1'b0, 1'b1}));
        cyc(8'h00, 1, 0, 8'h00, 0, 0);
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        chk("trap_pend_svc", 32'({pending, cpu_irq}), 32'({9'h001, 1'b0}));
`ifdef TRAP_PREEMPT_EN
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        chk("treq", 32'({cpu_irq, vector, in_service}), 32'({1'b1, 4'd0, 1'b1}));
        cyc(8'h00, 0, 0, 8'h00, 1, 0);
        chk("tsvc", 32'({pending, cpu_irq, in_service}), 32'({9'h000, 1'b0, 1'b1}));
        cyc(8'h00, 0, 0, 8'h00, 0, 1);
        chk("restore_v3", 32'({cpu_irq, vector, in_service}), 32'({1'b0, 4'd3, 1'b1}));
        cyc(8'h00, 0, 0, 8'h00, 0, 1);
        chk("final_eoi", 32'({cpu_irq, in_service}), 32'h0);
`else
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        chk("trap_waits", 32'({cpu_irq, vector, in_service}), 32'({1'b0, 4'd3, 1'b1}));
        cyc(8'h00, 0, 0, 8'h00, 0, 1);
        chk("v3_eoi", 32'({cpu_irq, in_service}), 32'h0);
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        chk("trap_after_eoi", 32'({cpu_irq, vector}), 32'h10);
        cyc(8'h00, 0, 0, 8'h00, 1, 0);
        cyc(8'h00, 0, 0, 8'h00, 0, 1);
        chk("trap_done", 32'({pending, cpu_irq, in_service}), 32'h0);
`endif

        // Reset asserted in REQ clears everything without waiting for a clock.
        cyc(8'h02, 0, 0, 8'h00, 0, 0);
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        chk("pre_reset_req", 32'({pending, cpu_irq, vector}), 32'({9'h004, 1'b1, 4'd2}));
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_reset", 32'({pending, cpu_irq, vector, in_service, mask}),
            32'({9'h000, 1'b0, 4'd0, 1'b0, 8'hFF}));
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        cyc(8'h00, 0, 0, 8'h00, 0, 1);
        chk("stray_eoi_idle", 32'({pending, cpu_irq, vector, in_service}), 32'h0);
        cyc(8'h00, 0, 0, 8'h00, 0, 0);
        chk("idle_after_reset", 32'({cpu_irq, in_service}), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Prioritised interrupt/trap controller between external event sources and the CPU core of `computer`.
- Synchronises and edge-detects `NUM_IRQ` interrupt lines plus one non-maskable trap line, and latches pending events.
- Arbitrates by fixed priority and presents a single request and vector to the CPU.
- Sequences the request → acknowledge → end-of-interrupt handshake so the CPU services exactly one event at a time.

Parameters:
- NUM_IRQ, 8, number of maskable interrupt inputs (1..15).
- VEC_W, 4, vector width; must satisfy 2^VEC_W > NUM_IRQ.
- SYNC_STAGES, 2, synchroniser flops per input (≥2).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- irq_in  in  NUM_IRQ  async interrupt lines; rising-edge triggered.
- trap  in  1  async fault line; rising-edge triggered, non-maskable.
- cfg_we  in  1  mask write strobe.
- cfg_mask  in  NUM_IRQ  mask write data (1 = masked).
- mask  out  NUM_IRQ  current mask register.
- pending  out  NUM_IRQ+1  pending bits; bit 0 = trap, bit i+1 = irq_in[i].
- cpu_irq  out  1  request to CPU.
- vector  out  VEC_W  source id: 0 = trap, i+1 = irq_in[i].
- cpu_ack  in  1  CPU accepts the request (single-cycle pulse).
- cpu_eoi  in  1  CPU finished the handler (single-cycle pulse).
- in_service  out  1  a handler is active.

Behaviour:
- Reset values: mask = all ones, pending = 0, cpu_irq = 0, vector = 0, in_service = 0, FSM = IDLE, synchronisers = 0.
- Each input passes through SYNC_STAGES flops. A rising edge is detected against one further delayed flop.
- A detected edge sets the matching pending bit. Level-high inputs do not re-trigger.
- Masking gates arbitration only. It never clears pending. A masked event fires when unmasked.
- cfg_we loads mask on the clock edge; the new mask affects arbitration from the next cycle.
- Eligible set = pending[0] OR (pending[NUM_IRQ:1] & ~mask). Priority: trap highest, then irq_in[0] … irq_in[NUM_IRQ-1] descending.
- FSM (all outputs registered):
  - IDLE: if the eligible set is non-empty → REQ. Latch the winner into vector, cpu_irq←1.
  - REQ: vector frozen; no preemption, even by trap. On cpu_ack → clear the winner's pending bit, cpu_irq←0, in_service←1, go to SERVICE.
  - SERVICE: new events accumulate in pending. On cpu_eoi → in_service←0, go to IDLE. Arbitration restarts the following cycle.
- cpu_ack outside REQ and cpu_eoi outside SERVICE are ignored.
- Latency: an input edge present before clock edge k gives pending set at edge k+SYNC_STAGES+1 and cpu_irq high at edge k+SYNC_STAGES+2.
- New edge on the same source in the same cycle as its ack-clear: set wins, so the bit stays pending.
- Edges on multiple sources in one cycle: all latched, serviced in priority order over successive rounds.
- Masking the winning source while in REQ: the request completes normally.
- Reset asserted mid-handshake: immediate return to reset values; pending events are lost.

Optional Feature:
- Macro TRAP_PREEMPT_EN.
- Defined:
  - A pending trap while in SERVICE, with a maskable handler active, raises cpu_irq with vector 0 and enters state TREQ.
  - cpu_ack → TSERVICE. The interrupted vector is saved in a one-deep register.
  - cpu_eoi in TSERVICE returns to SERVICE with the saved vector restored. in_service stays 1 throughout.
  - Nesting depth is 1; a trap during TSERVICE waits.
- Undefined: a trap during SERVICE waits in pending like any other source. TREQ and TSERVICE do not exist.

Test Plan:
- Reset then idle: reset=0 for 2 cycles → mask=all ones, cpu_irq=0, pending=0; irq_in[3] pulse while masked → pending[4]=1, cpu_irq stays 0.
- cfg_mask=0x00, irq_in[3] rises → cpu_irq=1 exactly SYNC_STAGES+2 edges later with vector=4; cpu_ack → cpu_irq=0, pending[4]=0, in_service=1; cpu_eoi → in_service=0.
- irq_in[5] and irq_in[1] rise in the same cycle, unmasked → first vector=2, after eoi second request vector=6; in each case only the serviced pending bit is cleared.
- trap and irq_in[0] rise together → vector=0 first; trap with mask=all ones still requested.
- Trap rises while in SERVICE for vector 3:
  - without TRAP_PREEMPT_EN, cpu_irq stays 0 until cpu_eoi, then vector=0;
  - with TRAP_PREEMPT_EN, cpu_irq=1 with vector=0 within one cycle of pending; after ack+eoi, vector=3 is restored with in_service=1.
- reset asserted in REQ → cpu_irq=0, pending=0 asynchronously; stray cpu_eoi in IDLE → no state change.
